// File: rtl/timer_capture.sv
// timer_capture: timestamps qualified edges of an asynchronous capture pin
// into a small circular FIFO of {edge type, TIME} entries.
// The pin is brought into the div_clk domain by a 2-flop synchronizer, and
// edges are detected against a flop holding the previous synchronized level.
// Optional feature: define TIMER_CAPTURE_FILTER_EN to insert a glitch filter
// between the synchronizer and the edge detector. The filter requires three
// consecutive equal samples, which adds two cycles of latency.
module timer_capture #(
  parameter int DEPTH = 4
) (
  input  logic                       rst,
  input  logic                       div_clk,
  input  logic                       en,
  input  logic [1:0]                 edge_sel,
  input  logic                       cap_in,
  input  logic [31:0]                time_val,
  input  logic                       pop,
  input  logic                       ovf_clr,
  output logic [31:0]                cap_data,
  output logic                       cap_edge,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Synchronizer, previous-level flop and control state
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          ovf_q, ovf_d;
`ifdef TIMER_CAPTURE_FILTER_EN
  logic          hist_q, hist_d;
  logic          filt_q, filt_d;
`endif

  // Entry storage: bit 32 = rising edge, bits 31:0 = timestamp
  logic [32:0]   mem_q [DEPTH];

  logic          lvl;
  logic          rise_evt;
  logic          fall_evt;
  logic          push_req;
  logic          fifo_empty;
  logic          fifo_full;
  logic          do_push;
  logic          do_pop;
  logic [32:0]   head;

  // Front end: synchronizer, optional glitch filter, edge qualification
  always_comb begin
    sync1_d = cap_in;
    sync2_d = sync1_q;
`ifdef TIMER_CAPTURE_FILTER_EN
    hist_d  = sync2_q;
    filt_d  = filt_q;
    // sync1, sync2 and hist hold three consecutive samples of the pin
    if ((sync1_q == sync2_q) && (sync2_q == hist_q)) begin
      filt_d = sync2_q;
    end
    lvl     = filt_q;
`else
    lvl     = sync2_q;
`endif
    // prev tracks the level every cycle, even while capture is disabled,
    // so re-enabling never manufactures a stale edge
    prev_d   = lvl;
    rise_evt = lvl & ~prev_q;
    fall_evt = ~lvl & prev_q;
    push_req = en & ((rise_evt & edge_sel[0]) | (fall_evt & edge_sel[1]));
  end

  // FIFO control: pointer updates and sticky overflow
  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop     = pop & ~fifo_empty;
    // a pop in the same cycle frees the slot for a push into a full FIFO
    do_push    = push_req & (~fifo_full | do_pop);
    wptr_d     = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d     = rptr_q + {{AW{1'b0}}, do_pop};
    ovf_d      = ovf_q;
    // a newly lost event wins over a clear in the same cycle
    if (push_req && fifo_full && !do_pop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge div_clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef TIMER_CAPTURE_FILTER_EN
      hist_q  <= 1'b0;
      filt_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
`ifdef TIMER_CAPTURE_FILTER_EN
      hist_q  <= hist_d;
      filt_q  <= filt_d;
`endif
    end
  end

  // Entry storage write; contents need no reset because the pointers gate reads
  always_ff @(posedge div_clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= {rise_evt, time_val};
    end
  end

  // Outputs taken straight from FIFO state, zeroed when empty
  always_comb begin
    head     = mem_q[rptr_q[AW-1:0]];
    cap_data = fifo_empty ? 32'd0 : head[31:0];
    cap_edge = fifo_empty ? 1'b0 : head[32];
    valid    = ~fifo_empty;
    count    = wptr_q - rptr_q;
    overflow = ovf_q;
    irq      = ~fifo_empty | ovf_q;
  end

endmodule

// File: tb/tb_timer_capture.sv
// Directed bench for timer_capture with a queue-based reference model.
module tb_timer_capture;

  localparam int DEPTH = 4;
`ifdef TIMER_CAPTURE_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        rst;
  logic        div_clk = 1'b0;
  logic        en;
  logic [1:0]  edge_sel;
  logic        cap_in;
  logic [31:0] time_val;
  logic        pop;
  logic        ovf_clr;
  logic [31:0] cap_data;
  logic        cap_edge;
  logic        valid;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic        overflow;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  timer_capture #(.DEPTH(DEPTH)) dut (
    .rst(rst), .div_clk(div_clk), .en(en), .edge_sel(edge_sel),
    .cap_in(cap_in), .time_val(time_val), .pop(pop), .ovf_clr(ovf_clr),
    .cap_data(cap_data), .cap_edge(cap_edge), .valid(valid),
    .count(count), .overflow(overflow), .irq(irq)
  );

  always #5 div_clk = ~div_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pin samples per edge, filtered level history, entry queue
  typedef struct packed { logic e; logic [31:0] t; } ent_t;
  ent_t       mq[$];
  logic       m_ovf = 1'b0;
  logic [2:0] samp = '0;   // samp[0] = pin sampled at previous edge
  logic [2:0] flv = '0;    // flv[0] = filtered level after previous edge
  logic       m_ev, m_lvl, m_qual, m_pop, m_full, m_newf;

  always @(posedge div_clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0;
      samp  = '0;
      flv   = '0;
    end else begin
`ifdef TIMER_CAPTURE_FILTER_EN
      // event when the filtered level changed one edge earlier
      m_ev   = (flv[0] != flv[1]);
      m_lvl  = flv[0];
      m_newf = (samp[0] == samp[1] && samp[1] == samp[2]) ? samp[0] : flv[0];
      flv    = {flv[1:0], m_newf};
`else
      // event when pin samples taken two and three edges ago differ
      m_ev   = (samp[1] != samp[2]);
      m_lvl  = samp[1];
`endif
      samp   = {samp[1:0], cap_in};
      m_qual = m_ev && en && (m_lvl ? edge_sel[0] : edge_sel[1]);
      m_full = (mq.size() == DEPTH);
      m_pop  = pop && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      if (m_qual && m_full && !m_pop) m_ovf = 1'b1;
      else begin
        if (m_qual) mq.push_back('{e: m_lvl, t: time_val});
        if (ovf_clr) m_ovf = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge div_clk) begin
    chk("m_cap_data", cap_data, (mq.size() > 0) ? mq[0].t : 32'd0);
    chk("m_cap_edge", {31'd0, cap_edge}, (mq.size() > 0) ? {31'd0, mq[0].e} : 32'd0);
    chk("m_valid", {31'd0, valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
    chk("m_count", {29'd0, count}, mq.size());
    chk("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("m_irq", {31'd0, irq}, ((mq.size() > 0) || m_ovf) ? 32'd1 : 32'd0);
  end

  task automatic tick();
    @(posedge div_clk);
    #1;
    time_val = time_val + 1;
    pop      = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  logic [31:0] t0, tr;

  initial begin
    rst = 1'b0; en = 1'b0; edge_sel = 2'b00; cap_in = 1'b0;
    pop = 1'b0; ovf_clr = 1'b0; time_val = 32'd0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_data", cap_data, 32'd0);
    rst = 1'b1;

    // Single rising capture: time_val is 100 at the sampling edge
    en = 1'b1; edge_sel = 2'b01;
    repeat (2) tick();
    time_val = 32'd100; cap_in = 1'b1;
    repeat (LAT) tick();
    chk("lat_valid_early", {31'd0, valid}, 32'd0);
    tick();
    chk("rise_valid", {31'd0, valid}, 32'd1);
    chk("rise_data", cap_data, 32'd100 + LAT);
    chk("rise_edge", {31'd0, cap_edge}, 32'd1);
    chk("rise_count", {29'd0, count}, 32'd1);
    chk("rise_irq", {31'd0, irq}, 32'd1);
    pop = 1'b1; tick();
    chk("pop_valid", {31'd0, valid}, 32'd0);
    chk("pop_data", cap_data, 32'd0);

    // Five alternating transitions into a 4-deep FIFO, no pop
    edge_sel = 2'b11;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) t0 = time_val;
      cap_in = ~cap_in;
      repeat (4) tick();
    end
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_ovf", {31'd0, overflow}, 32'd1);
    chk("full_head", cap_data, t0 + LAT);
    chk("full_edge", {31'd0, cap_edge}, 32'd0);
    ovf_clr = 1'b1; tick();
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_irq", {31'd0, irq}, 32'd1);

    // Push and pop on the same edge while full
    cap_in = ~cap_in;
    repeat (LAT) tick();
    pop = 1'b1; tick();
    chk("pp_count", {29'd0, count}, 32'd4);
    chk("pp_ovf", {31'd0, overflow}, 32'd0);
    chk("pp_head", cap_data, t0 + 4 + LAT);
    chk("pp_edge", {31'd0, cap_edge}, 32'd1);

    // Drain, then pop on empty
    repeat (4) begin pop = 1'b1; tick(); end
    pop = 1'b1; tick();
    chk("pe_count", {29'd0, count}, 32'd0);
    chk("pe_valid", {31'd0, valid}, 32'd0);
    chk("pe_data", cap_data, 32'd0);

    // Capture disabled while the pin toggles, then re-enabled on a steady pin
    en = 1'b0;
    repeat (3) begin cap_in = ~cap_in; repeat (3) tick(); end
    repeat (8) tick();
    chk("dis_count", {29'd0, count}, 32'd0);
    en = 1'b1;
    repeat (4) tick();
    chk("reen_count", {29'd0, count}, 32'd0);
    cap_in = ~cap_in;
    repeat (6) tick();
    chk("reen_push", {29'd0, count}, 32'd1);

    // Reset one cycle after a rising pin, pin held high through release
    edge_sel = 2'b01; cap_in = 1'b0;
    repeat (6) tick();
    cap_in = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("ar_valid", {31'd0, valid}, 32'd0);
    chk("ar_count", {29'd0, count}, 32'd0);
    chk("ar_irq", {31'd0, irq}, 32'd0);
    chk("ar_data", cap_data, 32'd0);
    repeat (2) tick();
    rst = 1'b1; tr = time_val;
    repeat (LAT) tick();
    chk("rel_early", {29'd0, count}, 32'd0);
    tick();
    chk("rel_count", {29'd0, count}, 32'd1);
    chk("rel_edge", {31'd0, cap_edge}, 32'd1);
    chk("rel_data", cap_data, tr + LAT);

`ifdef TIMER_CAPTURE_FILTER_EN
    // Glitch filter: 2-cycle pulse rejected, 4-cycle pulse captured
    pop = 1'b1; tick();
    edge_sel = 2'b11; cap_in = 1'b0;
    repeat (8) tick();
    cap_in = 1'b1; repeat (2) tick(); cap_in = 1'b0;
    repeat (8) tick();
    chk("flt_short", {29'd0, count}, 32'd0);
    t0 = time_val; cap_in = 1'b1;
    repeat (4) tick();
    cap_in = 1'b0;
    chk("flt_early", {29'd0, count}, 32'd0);
    tick();
    chk("flt_rise", {29'd0, count}, 32'd1);
    chk("flt_data", cap_data, t0 + 4);
    repeat (8) tick();
    chk("flt_both", {29'd0, count}, 32'd2);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_capture.md
TIMER_CAPTURE -- requirements
Module: timer_capture

Interface
REQ-001 Parameter DEPTH, default 4, capture FIFO entries; power of two, 2..16.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 div_clk  input  1  prescaled timer clock, same net that increments TIME; all state on its rising edge.
REQ-004 en  input  1  capture enable, synchronous to div_clk.
REQ-005 edge_sel  input  2  00 none, 01 rising, 10 falling, 11 both.
REQ-006 cap_in  input  1  external capture pin, asynchronous.
REQ-007 time_val  input  32  current TIME count, div_clk domain.
REQ-008 pop  input  1  single-cycle pulse, removes head entry.
REQ-009 ovf_clr  input  1  single-cycle pulse, clears overflow.
REQ-010 cap_data  output  32  timestamp of head entry; 0 when empty.
REQ-011 cap_edge  output  1  head entry edge type, 1 rising / 0 falling; 0 when empty.
REQ-012 valid  output  1  FIFO non-empty.
REQ-013 count  output  $clog2(DEPTH+1)  entries held.
REQ-014 overflow  output  1  sticky, event lost.
REQ-015 irq  output  1  level interrupt, equals valid | overflow.

Function
REQ-016 cap_in passes a 2-flop synchronizer (s); a third flop p holds previous s; edge event when s != p.
REQ-017 Rising event (s=1,p=0) qualifies if edge_sel[0]; falling (s=0,p=1) if edge_sel[1]; only when en=1.
REQ-018 Qualified event pushes {edge type, time_val} at the same div_clk edge at which it is detected (s != p before that edge); p updates to s every cycle regardless of en.
REQ-019 Latency: cap_in transition sampled at edge N -> push and valid=1 after edge N+2; cap_data = time_val present before edge N+2.
REQ-020 FIFO: circular, read/write pointers one bit wider than log2(DEPTH); full when MSBs differ and rest equal; wrap at DEPTH.
REQ-021 Outputs cap_data/cap_edge/valid/count registered directly from FIFO state, no extra stage.
REQ-022 pop when empty: ignored, no pointer change.
REQ-023 Push when full without pop: event dropped, FIFO unchanged, overflow set.
REQ-024 Push and pop same cycle when full: both performed, count unchanged, overflow unchanged.
REQ-025 Push and pop same cycle when empty: push only.
REQ-026 ovf_clr and new overflow same cycle: overflow remains 1.
REQ-027 en falling: FIFO contents retained, popping allowed; re-enable produces no event unless s != p at that cycle.
REQ-028 edge_sel change takes effect on the next detected event; no flush.

Reset
REQ-029 rst low: synchronizer, p, pointers, overflow cleared to 0 immediately; cap_data=0, cap_edge=0, valid=0, count=0, irq=0.
REQ-030 rst mid-event: in-flight edge discarded; first event after release needs a fresh transition through the synchronizer (p reset 0, so cap_in high at release yields a rising event 2 cycles later if enabled).

Configuration
REQ-031 Macro TIMER_CAPTURE_FILTER_EN defined: glitch filter between synchronizer and p; filtered s changes only after 3 consecutive equal synchronizer samples; latency becomes N+4; filter state resets to 0.
REQ-032 Macro undefined: no filter; latency per REQ-019; pulses of 1 div_clk cycle are captured.

Verification
REQ-033 edge_sel=01, en=1, time_val incrementing from 100, cap_in 0->1 sampled at edge 5 -> valid=1 after edge 7, cap_data=102, cap_edge=1, count=1, irq=1.
REQ-034 edge_sel=11, 5 alternating transitions 4 cycles apart, DEPTH=4, no pop -> count=4, overflow=1, head = first timestamp; ovf_clr -> overflow=0, irq stays 1.
REQ-035 FIFO full, push and pop same cycle -> count stays 4, overflow stays 0, new head = second entry.
REQ-036 pop on empty FIFO -> count=0, valid=0, cap_data=0, no pointer move; en=0 with cap_in toggling -> no entries.
REQ-037 rst asserted 1 cycle after cap_in rise -> all outputs 0 immediately; after release with cap_in held 1 -> one rising entry.
REQ-038 With TIMER_CAPTURE_FILTER_EN, 2-cycle cap_in pulse -> no entry; 4-cycle pulse -> rising and falling entries, rising at detection N+4.
